swap_ctrl: RTL

SWAP_CTRL -- requirements
Module: swap_ctrl

---
 rtl/sisc_pkg.sv | 16 +
 rtl/swap_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the swap controller: default register-file geometry
// and the controller state encoding.
package sisc_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WR_RS = 3'd2,
        WR_RT = 3'd3,
        DONE  = 3'd4
    } swap_state_e;

endpackage

// File: rtl/swap_ctrl.sv
// Swaps the contents of two register-file entries: one read cycle for both
// operands, then up to two write cycles steered by out_sel.
module swap_ctrl
    import sisc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic              out_sel,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    swap_state_e       state, state_nxt;
    logic [ADDR_W-1:0] rs_q, rt_q;
    logic [DATA_W-1:0] val_rs, val_rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rs_q   <= '0;
            rt_q   <= '0;
            val_rs <= '0;
            val_rt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                rs_q <= rs_addr;
                rt_q <= rt_addr;
            end
            if (state == READ) begin
                val_rs <= rd_data_a;
                val_rt <= rd_data_b;
            end
        end
    end

    assign rd_addr_a = rs_q;
    assign rd_addr_b = rt_q;

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        wr_en     = 1'b0;
        out_sel   = 1'b0;
        wr_data   = '0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = READ;
            end
            READ:  state_nxt = (rs_q == rt_q) ? DONE : WR_RS;
            WR_RS: begin
                wr_en     = 1'b1;
                out_sel   = 1'b1;
                wr_data   = val_rt;
                state_nxt = WR_RT;
            end
            WR_RT: begin
                wr_en     = 1'b1;
                wr_data   = val_rs;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
        // A reset cycle must not let a pending write reach the register file.
        if (rst) begin
            busy    = 1'b0;
            done    = 1'b0;
            wr_en   = 1'b0;
            out_sel = 1'b0;
            wr_data = '0;
        end
    end

endmodule
